// File: rtl/mem_check_pkg.sv
// Shared types and constants for the memory readback/MISR checker.
// The fill pattern is expressed per byte lane so any multiple-of-8 word width can use it.
package mem_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [31:0] DEF_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] DEF_SEED = 32'hFFFF_FFFF;

  // Byte carried by every lane of word k during fill.
  function automatic logic [7:0] pattern(input logic [7:0] k);
    return k;
  endfunction

endpackage

// File: rtl/misr_fold.sv
// XOR-folds one memory word down to SIG_W bits and applies a single MISR shift step.
module misr_fold #(
  parameter int              WID_MEM = 128,
  parameter int              SIG_W   = 32,
  parameter logic [SIG_W-1:0] POLY   = 32'h04C1_1DB7
) (
  input  logic [SIG_W-1:0]   i_sig,
  input  logic [WID_MEM-1:0] i_data,
  output logic [SIG_W-1:0]   o_sig
);

  logic [SIG_W-1:0] w_fold;

  // Fold all SIG_W-wide slices of the word together.
  always_comb begin
    w_fold = '0;
    for (int i = 0; i < WID_MEM / SIG_W; i++) begin
      w_fold = w_fold ^ i_data[i*SIG_W +: SIG_W];
    end
  end

  assign o_sig = {i_sig[SIG_W-2:0], 1'b0} ^ (i_sig[SIG_W-1] ? POLY : '0) ^ w_fold;

endmodule

// File: rtl/mem_readback_misr.sv
// Fill/readback sequencer for a read-first memory with no write enable; compresses
// a full read sweep into a MISR signature. Outside fill every write re-stores last cycle's read.
module mem_readback_misr
  import mem_check_pkg::*;
#(
  parameter int               WID_MEM   = 128,
  parameter int               DEPTH_MEM = 256,
  parameter int               AW        = 8,
  parameter int               SIG_W     = 32,
  parameter logic [SIG_W-1:0] POLY      = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED      = DEF_SEED
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_fill,
  input  logic [SIG_W-1:0]   i_expected_sig,
  input  logic [WID_MEM-1:0] i_dout,
  output logic [AW-1:0]      o_raddr,
  output logic [AW-1:0]      o_waddr,
  output logic [WID_MEM-1:0] o_din,
  output logic               o_busy,
  output logic               o_done,
  output logic [SIG_W-1:0]   o_signature,
  output logic               o_match
);

  state_e             r_state;
  logic [AW-1:0]      r_k;
  logic [AW-1:0]      r_raddr;
  logic [AW-1:0]      r_raddr_q;
  logic               r_busy;
  logic               r_done;
  logic [SIG_W-1:0]   r_sig;
  logic [SIG_W-1:0]   r_exp;
  logic               r_match;

  logic               w_last;
  logic [7:0]         w_k8;
  logic [WID_MEM-1:0] w_pat;
  logic [SIG_W-1:0]   w_sig_next;

  assign w_last = (r_k == AW'(DEPTH_MEM - 1));
  assign w_k8   = 8'(r_k);
  assign w_pat  = {(WID_MEM / 8){pattern(w_k8)}};

  misr_fold #(
    .WID_MEM (WID_MEM),
    .SIG_W   (SIG_W),
    .POLY    (POLY)
  ) u_fold (
    .i_sig  (r_sig),
    .i_data (i_dout),
    .o_sig  (w_sig_next)
  );

  // Sequencer FSM with registered read address, status and signature.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_raddr <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sig   <= SEED;
      r_exp   <= '0;
      r_match <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= i_fill ? ST_FILL : ST_READ;
            r_k     <= '0;
            r_sig   <= SEED;
            r_exp   <= i_expected_sig;
            r_busy  <= 1'b1;
          end
        end
        ST_FILL: begin
          r_k <= r_k + AW'(1);
          if (w_last) begin
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          r_k <= r_k + AW'(1);
          // dout only carries sweep data from the second READ cycle on.
          if (r_k != '0) begin
            r_sig <= w_sig_next;
          end
          if (w_last) begin
            r_state <= ST_DRAIN;
            r_raddr <= '0;
          end else begin
            r_raddr <= r_k + AW'(1);
          end
        end
        ST_DRAIN: begin
          r_sig   <= w_sig_next;
          r_match <= (w_sig_next == r_exp);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Unreset copy of the read address: keeps write-back non-destructive across reset.
  always_ff @(posedge i_clk) begin
    r_raddr_q <= r_raddr;
  end

  // Write mux: pattern during fill, otherwise rewrite the word read last cycle.
  always_comb begin
    if (r_state == ST_FILL) begin
      o_waddr = r_k;
      o_din   = w_pat;
    end else begin
      o_waddr = r_raddr_q;
      o_din   = i_dout;
    end
  end

  assign o_raddr     = r_raddr;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_signature = r_sig;
  assign o_match     = r_match;

endmodule

// File: tb/tb_mem_readback_misr.sv
// Self-checking bench: read-first memory model plus a signature model computed from the array image.
module tb_mem_readback_misr;

  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  localparam logic [31:0] SEED = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         fill = 1'b0;
  logic [31:0]  expected_sig = 32'h0;
  logic [127:0] dout;
  logic [7:0]   raddr, waddr;
  logic [127:0] din;
  logic         busy, done, match;
  logic [31:0]  signature;

  logic [127:0] mem    [256];
  logic [127:0] bd_img [256];
  logic [127:0] snap   [256];
  logic         bd_load = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_readback_misr dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_fill         (fill),
    .i_expected_sig (expected_sig),
    .i_dout         (dout),
    .o_raddr        (raddr),
    .o_waddr        (waddr),
    .o_din          (din),
    .o_busy         (busy),
    .o_done         (done),
    .o_signature    (signature),
    .o_match        (match)
  );

  // Read-first memory with an all-array backdoor load taken while the sequencer is parked.
  always @(posedge clk) begin
    if (bd_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= bd_img[i];
      dout <= bd_img[raddr];
    end else begin
      dout <= mem[raddr];
      mem[waddr] <= din;
    end
  end

  function automatic logic [127:0] pat_word(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {16{b}};
  endfunction

  // Signature of the image in snap: one MISR step per word, ascending address.
  function automatic logic [31:0] model_sig();
    logic [31:0] s, f;
    logic [127:0] w;
    s = SEED;
    for (int k = 0; k < 256; k++) begin
      w = snap[k];
      f = w[31:0] ^ w[63:32] ^ w[95:64] ^ w[127:96];
      if (s[31]) s = ((s << 1) ^ POLY) ^ f;
      else       s = (s << 1) ^ f;
    end
    return s;
  endfunction

  function automatic int mem_diffs();
    int d;
    d = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== snap[k]) d++;
    return d;
  endfunction

  task automatic load_image();
    @(negedge clk);
    bd_load = 1'b1;
    @(negedge clk);
    bd_load = 1'b0;
    for (int k = 0; k < 256; k++) snap[k] = bd_img[k];
  endtask

  // Issues start and follows the run until done; optional stray start at cycle poke_at.
  task automatic run_op(input logic f, input logic [31:0] e, input int poke_at, input bit b2b,
                        output int n_busy, output int n_done_at);
    if (!b2b) @(negedge clk);
    start = 1'b1; fill = f; expected_sig = e;
    @(negedge clk);
    start = 1'b0; fill = $urandom_range(0, 1); expected_sig = $urandom;
    n_busy = 0; n_done_at = 0;
    for (int c = 1; c <= 2000; c++) begin
      if (done) begin
        n_done_at = c;
        break;
      end
      if (busy) n_busy++;
      if (c == poke_at) begin
        start = 1'b1; fill = ~f; expected_sig = ~e;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b want=0", done); end
    checks++; if (raddr !== 8'd0) begin failures++; $display("FAIL reset_raddr got=%0d want=0", raddr); end
    checks++; if (signature !== SEED) begin failures++; $display("FAIL reset_sig got=%h want=%h", signature, SEED); end
    checks++; if (match !== 1'b0) begin failures++; $display("FAIL reset_match got=%0b want=0", match); end
  endtask

  task automatic test_read_only();
    int nb, nd;
    logic [31:0] exp_s;
    for (int k = 0; k < 256; k++) bd_img[k] = pat_word(k);
    load_image();
    exp_s = model_sig();
    run_op(1'b0, exp_s, 0, 1'b0, nb, nd);
    checks++; if (nb != 257) begin failures++; $display("FAIL ro_busy_cycles got=%0d want=257", nb); end
    checks++; if (nd != 258) begin failures++; $display("FAIL ro_done_cycle got=%0d want=258", nd); end
    checks++; if (signature !== exp_s) begin failures++; $display("FAIL ro_sig got=%h want=%h", signature, exp_s); end
    checks++; if (match !== 1'b1) begin failures++; $display("FAIL ro_match got=%0b want=1", match); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL ro_done_pulse got=%0b want=0", done); end
    checks++; if (signature !== exp_s) begin failures++; $display("FAIL ro_sig_hold got=%h want=%h", signature, exp_s); end
    checks++; if (mem_diffs() != 0) begin failures++; $display("FAIL ro_nondestructive got=%0d want=0", mem_diffs()); end
  endtask

  task automatic test_back_to_back();
    int nb, nd;
    logic [31:0] exp_s;
    for (int k = 0; k < 256; k++) bd_img[k] = {$urandom, $urandom, $urandom, $urandom};
    load_image();
    exp_s = model_sig();
    run_op(1'b0, exp_s, 0, 1'b0, nb, nd);
    checks++; if (signature !== exp_s) begin failures++; $display("FAIL b2b_sig1 got=%h want=%h", signature, exp_s); end
    run_op(1'b0, exp_s, 0, 1'b1, nb, nd);
    checks++; if (nd != 258) begin failures++; $display("FAIL b2b_done_cycle got=%0d want=258", nd); end
    checks++; if (signature !== exp_s) begin failures++; $display("FAIL b2b_sig2 got=%h want=%h", signature, exp_s); end
    checks++; if (match !== 1'b1) begin failures++; $display("FAIL b2b_match got=%0b want=1", match); end
    @(negedge clk);
    checks++; if (mem_diffs() != 0) begin failures++; $display("FAIL b2b_nondestructive got=%0d want=0", mem_diffs()); end
  endtask

  task automatic test_fill();
    int nb, nd;
    logic [31:0] exp_s;
    for (int k = 0; k < 256; k++) bd_img[k] = '0;
    load_image();
    for (int k = 0; k < 256; k++) snap[k] = pat_word(k);
    exp_s = model_sig();
    run_op(1'b1, exp_s, 0, 1'b0, nb, nd);
    checks++; if (nb != 513) begin failures++; $display("FAIL fill_busy_cycles got=%0d want=513", nb); end
    checks++; if (nd != 514) begin failures++; $display("FAIL fill_done_cycle got=%0d want=514", nd); end
    checks++; if (signature !== exp_s) begin failures++; $display("FAIL fill_sig got=%h want=%h", signature, exp_s); end
    checks++; if (match !== 1'b1) begin failures++; $display("FAIL fill_match got=%0b want=1", match); end
    @(negedge clk);
    checks++; if (mem_diffs() != 0) begin failures++; $display("FAIL fill_image got=%0d diffs want=0", mem_diffs()); end
  endtask

  task automatic test_corrupt();
    int nb, nd, bitpos;
    logic [31:0] old_s, new_s;
    for (int k = 0; k < 256; k++) bd_img[k] = pat_word(k);
    load_image();
    old_s = model_sig();
    bitpos = $urandom_range(0, 127);
    bd_img[37][bitpos] = ~bd_img[37][bitpos];
    load_image();
    new_s = model_sig();
    run_op(1'b0, old_s, 0, 1'b0, nb, nd);
    checks++; if (match !== 1'b0) begin failures++; $display("FAIL corrupt_match got=%0b want=0", match); end
    checks++; if (signature === old_s) begin failures++; $display("FAIL corrupt_sig_differs got=%h must differ from %h", signature, old_s); end
    checks++; if (signature !== new_s) begin failures++; $display("FAIL corrupt_sig got=%h want=%h", signature, new_s); end
  endtask

  task automatic test_random();
    int nb, nd;
    logic f;
    logic [31:0] exp_s, e;
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < 256; k++) bd_img[k] = {$urandom, $urandom, $urandom, $urandom};
      load_image();
      f = $urandom_range(0, 1);
      if (f) for (int k = 0; k < 256; k++) snap[k] = pat_word(k);
      exp_s = model_sig();
      e = ($urandom_range(0, 1) != 0) ? exp_s : (exp_s ^ ($urandom | 32'h1));
      run_op(f, e, 0, 1'b0, nb, nd);
      checks++; if (nb != (f ? 513 : 257)) begin failures++; $display("FAIL rnd_busy it=%0d got=%0d want=%0d", it, nb, f ? 513 : 257); end
      checks++; if (signature !== exp_s) begin failures++; $display("FAIL rnd_sig it=%0d got=%h want=%h", it, signature, exp_s); end
      checks++; if (match !== (e == exp_s)) begin failures++; $display("FAIL rnd_match it=%0d got=%0b want=%0b", it, match, e == exp_s); end
      @(negedge clk);
      checks++; if (mem_diffs() != 0) begin failures++; $display("FAIL rnd_image it=%0d got=%0d diffs want=0", it, mem_diffs()); end
    end
  endtask

  task automatic test_reset_mid();
    int nb, nd;
    logic [31:0] exp_s;
    for (int k = 0; k < 256; k++) bd_img[k] = {$urandom, $urandom, $urandom, $urandom};
    load_image();
    exp_s = model_sig();
    @(negedge clk);
    start = 1'b1; fill = 1'b0; expected_sig = exp_s;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    checks++; if (raddr !== 8'd100) begin failures++; $display("FAIL rst_mid_pos got=%0d want=100", raddr); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%0b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_mid_done got=%0b want=0", done); end
    checks++; if (raddr !== 8'd0) begin failures++; $display("FAIL rst_mid_raddr got=%0d want=0", raddr); end
    repeat (3) @(negedge clk);
    checks++; if (mem_diffs() != 0) begin failures++; $display("FAIL rst_mid_image got=%0d diffs want=0", mem_diffs()); end
    run_op(1'b0, exp_s, 0, 1'b0, nb, nd);
    checks++; if (nd != 258) begin failures++; $display("FAIL rst_mid_rerun_done got=%0d want=258", nd); end
    checks++; if (signature !== exp_s) begin failures++; $display("FAIL rst_mid_rerun_sig got=%h want=%h", signature, exp_s); end
    checks++; if (match !== 1'b1) begin failures++; $display("FAIL rst_mid_rerun_match got=%0b want=1", match); end
  endtask

  task automatic test_start_ignored();
    int nb, nd, extra;
    logic [31:0] exp_s;
    for (int k = 0; k < 256; k++) bd_img[k] = {$urandom, $urandom, $urandom, $urandom};
    load_image();
    exp_s = model_sig();
    run_op(1'b0, exp_s, 11, 1'b0, nb, nd);
    checks++; if (nd != 258) begin failures++; $display("FAIL ign_done_cycle got=%0d want=258", nd); end
    checks++; if (nb != 257) begin failures++; $display("FAIL ign_busy_cycles got=%0d want=257", nb); end
    checks++; if (match !== 1'b1) begin failures++; $display("FAIL ign_match got=%0b want=1", match); end
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL ign_extra_activity got=%0d want=0", extra); end
    checks++; if (mem_diffs() != 0) begin failures++; $display("FAIL ign_image got=%0d diffs want=0", mem_diffs()); end
  endtask

  initial begin
    test_reset();
    test_read_only();
    test_back_to_back();
    test_fill();
    test_corrupt();
    test_random();
    test_reset_mid();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_readback_misr.md
Name: mem_readback_misr

Overview:
- Sequencer that sits directly upstream of the `memory` block and drives its `raddr`, `waddr` and `din`.
- It also consumes the memory's `dout`.
- On `start` it optionally fills the array with an address pattern, then sweeps every address and compresses the read data into a MISR signature.
- The signature is compared against an expected value, so bitstream memory reinit can be checked on hardware without disturbing contents.
- The memory writes every cycle and has no write enable, so this block must always present a non-destructive write (write-back of the word just read) outside fill.

Parameters:
- `WID_MEM`, 128, memory word width; must be a multiple of `SIG_W`.
- `DEPTH_MEM`, 256, number of words; power of two, ≥2.
- `AW`, 8, address width; `AW = log2(DEPTH_MEM)`.
- `SIG_W`, 32, signature width.
- `POLY`, 32'h04C11DB7, MISR feedback polynomial.
- `SEED`, 32'hFFFFFFFF, signature value at the start of each read sweep.

Ports:
- `clk`  in  1  single clock; one clock for the block.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  single-cycle request; ignored while busy.
- `fill`  in  1  sampled with `start`: 1 = fill then read, 0 = read only.
- `expected_sig`  in  `SIG_W`  reference signature; sampled with `start`.
- `dout`  in  `WID_MEM`  memory read data; valid one cycle after `raddr`.
- `raddr`  out  `AW`  memory read address (registered).
- `waddr`  out  `AW`  memory write address (combinational).
- `din`  out  `WID_MEM`  memory write data (combinational).
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the signature is final.
- `signature`  out  `SIG_W`  MISR result; held until the next `start`.
- `match`  out  1  `signature == expected_sig`; updated with `done`, held.

Behaviour:
- States: IDLE, FILL, READ, DRAIN.
- Reset values: state=IDLE, `raddr`=0, `busy`=0, `done`=0, `signature`=`SEED`, `match`=0. Power-on register values equal reset values.
- `raddr_q` (previous `raddr`) is NOT reset; it always follows `raddr`.
- Write mux:
  - In FILL: `waddr` = k, `din` = pattern(k) = {`WID_MEM`/8 copies of k[7:0]}.
  - In all other states: `waddr` = `raddr_q`, `din` = `dout`. This rewrites the word read last cycle with its own value.
- Read address: `raddr` = k in READ; 0 in every other state, including FILL. Address 0 is the park address.
- IDLE: on `start`, go to FILL if `fill`=1, else READ. Sweep counter k←0, `signature`←`SEED`, `expected_sig` latched, `busy`←1.
- FILL: one write per cycle, k = 0..`DEPTH_MEM`-1, then go to READ with k←0.
  - Ascending order plus `raddr`=0 guarantees the first READ write-back of address 0 carries pattern(0). The memory is read-first; address 0 was already written at FILL cycle 0.
- READ: `raddr`=k for k = 0..`DEPTH_MEM`-1. The wrap of k from `DEPTH_MEM`-1 moves the FSM to DRAIN.
- DRAIN: one cycle. `raddr`=0; write-back of address `DEPTH_MEM`-1; then IDLE.
- Signature update: on each of the `DEPTH_MEM` cycles where `dout` holds read data (READ cycles 1..end plus DRAIN):
  - f = XOR of all `SIG_W` slices of `dout`.
  - `sig` ← ({`sig`[`SIG_W`-2:0],0} ^ (`sig`[`SIG_W`-1] ? `POLY` : 0)) ^ f.
- Completion: `done`=1 and `match` registered in the cycle after DRAIN, together with `busy`←0.
- Cycle counts: read-only run = `DEPTH_MEM`+1 busy cycles; fill run = 2·`DEPTH_MEM`+1.
- `start` while busy: ignored, no effect.
- `start` in the same cycle as `done`: accepted.
- Reset mid-operation: FSM→IDLE, `raddr`→0, `busy`/`done`/`match`→0.
  - Reset in READ or DRAIN: the next-cycle write-back (`waddr`=old `raddr`, `din`=its data) stays non-destructive.
  - Reset during FILL leaves the array partially filled; the content of address 0 is then unspecified.
- `reset` must be held ≥2 cycles at bring-up so the park loop is established.

Decomposition:
- Package `mem_check_pkg`: state enum (IDLE, FILL, READ, DRAIN), default `POLY`/`SEED` constants, and a `pattern(k)` function.
- One sub-module, `misr_fold`: combinational XOR-fold of `WID_MEM`→`SIG_W` plus the single MISR step. It is reused by future width variants.

Test Plan:
- Read-only run on an array initialised with word[k] = {16{k}}: `start`, `fill`=0 → `busy` for 257 cycles, `done` pulse at cycle 258. `signature` equals the reference model; `expected_sig` = model value → `match`=1.
- Same run twice back-to-back (`start` coincident with `done`) → identical `signature`; a memory dump compared against the init file shows zero differences (non-destructive).
- Fill run on an all-zero array: `fill`=1 → `busy` 513 cycles. Dump gives word[k] = {16{k}} for k = 0..255. `signature` equals the read-only signature of that image.
- Corrupt one bit of word[37] via backdoor, then read-only run with the old expected value → `match`=0 and `signature` ≠ expected.
- Assert `reset` for 2 cycles at READ k=100 → `busy`/`done`=0, `raddr`=0, no word in the array changed. A following full run completes normally.
- `start` pulsed at READ k=10 → ignored; still exactly one `done`, at the original cycle.
